// File: rtl/neural_network.sv
// rtl/neural_network.sv - two-layer fixed-point perceptron digit classifier, serial MAC.
// Optional NN_PERF_COUNTER_EN adds cycle_count (cycles from accepted start to done).
module neural_network_datapath #(
  parameter int N_IN  = 62,
  parameter int N_HID = 30,
  parameter int N_OUT = 10,
  parameter int DW    = 8,
  parameter int AW    = 24,
  parameter int JW    = 5,
  parameter int SW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW*N_IN-1:0]   inputLayer,
  input  logic                 load,
  input  logic                 hid,
  input  logic                 out_phase,
  input  logic [JW-1:0]        idx,
  input  logic [SW-1:0]        sub,
  output logic [3:0]           result
);
  localparam int WHW = $clog2(N_HID*N_IN);
  localparam int WOW = $clog2(N_OUT*N_HID);
  localparam int HJW = $clog2(N_HID);
  localparam int BOW = $clog2(N_OUT);
  localparam logic [SW-1:0] HID_MAC_END = SW'(N_IN);
  localparam logic [SW-1:0] OUT_MAC_END = SW'(N_HID);
  localparam logic [JW-1:0] LAST_CLASS  = JW'(N_OUT-1);

  reg [7:0] Wh_Array [0:N_HID*N_IN-1];
  reg [7:0] Bh_Array [0:N_HID-1];
  reg [7:0] Wo_Array [0:N_OUT*N_HID-1];
  reg [7:0] Bo_Array [0:N_OUT-1];

  logic [DW*N_IN-1:0]      x_reg;
  logic [6:0]              h [N_HID];
  logic signed [AW-1:0]    acc, omax;
  logic [3:0]              best;

  logic [SW-1:0]           m;
  logic signed [DW-1:0]    x_tc, wh_tc, wo_tc, b_tc, hv;
  logic signed [2*DW-1:0]  prod_h, prod_o;
  logic signed [AW-1:0]    bias_ext, shifted;
  logic [6:0]              h_new;
  logic                    take;

  function automatic logic signed [DW-1:0] sm2tc(input logic [DW-1:0] v);
    logic signed [DW-1:0] mag;
    mag = {1'b0, v[DW-2:0]};
    return v[DW-1] ? -mag : mag;
  endfunction

  always_comb begin
    m        = (sub == '0) ? '0 : sub - 1'b1;
    x_tc     = sm2tc(x_reg[int'(m)*DW +: DW]);
    wh_tc    = sm2tc(Wh_Array[WHW'(int'(idx)*N_IN + int'(m))]);
    wo_tc    = sm2tc(Wo_Array[WOW'(int'(idx)*N_HID + int'(m))]);
    hv       = $signed({1'b0, h[HJW'(m)]});
    prod_h   = x_tc * wh_tc;
    prod_o   = hv * wo_tc;
    b_tc     = hid ? sm2tc(Bh_Array[HJW'(idx)]) : sm2tc(Bo_Array[BOW'(idx)]);
    bias_ext = AW'(b_tc) <<< 7;
    shifted  = acc >>> 7;
    // ReLU then saturate to the 7-bit hidden range
    if (shifted[AW-1])
      h_new = '0;
    else if (|shifted[AW-2:7])
      h_new = 7'd127;
    else
      h_new = shifted[6:0];
    take = (idx == '0) || (acc > omax);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg  <= '0;
      acc    <= '0;
      omax   <= '0;
      best   <= '0;
      result <= '0;
      for (int j = 0; j < N_HID; j++) h[j] <= '0;
    end else begin
      if (load) x_reg <= inputLayer;
      if (hid) begin
        if (sub == '0)               acc <= bias_ext;
        else if (sub <= HID_MAC_END) acc <= acc + AW'(prod_h);
        else                         h[HJW'(idx)] <= h_new;
      end
      if (out_phase) begin
        if (sub == '0)               acc <= bias_ext;
        else if (sub <= OUT_MAC_END) acc <= acc + AW'(prod_o);
        else begin
          if (take) begin
            omax <= acc;
            best <= 4'(idx);
          end
          if (idx == LAST_CLASS) result <= take ? 4'(idx) : best;
        end
      end
    end
  end
endmodule

module neural_network #(
  parameter int N_IN  = 62,
  parameter int N_HID = 30,
  parameter int N_OUT = 10,
  parameter int DW    = 8,
  parameter int AW    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DW*N_IN-1:0] inputLayer,
  output logic [3:0]         result,
`ifdef NN_PERF_COUNTER_EN
  output logic               ready,
  output logic [15:0]        cycle_count
`else
  output logic               ready
`endif
);
  localparam int JW = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int SW = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 2);
  localparam logic [SW-1:0] HID_END = SW'(N_IN + 1);
  localparam logic [SW-1:0] OUT_END = SW'(N_HID + 1);
  localparam logic [JW-1:0] HID_LASTJ = JW'(N_HID - 1);
  localparam logic [JW-1:0] OUT_LASTJ = JW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HID, OUT, DONE} state_t;
  state_t state, nxt;

  logic          start_d, accept;
  logic [JW-1:0] idx;
  logic [SW-1:0] sub;
  logic          load, hid, out_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_d <= 1'b0;
      idx     <= '0;
      sub     <= '0;
    end else begin
      state   <= nxt;
      start_d <= start;
      // idx walks neurons/classes; sub walks bias, MAC terms, then write/compare
      case (state)
        HID: if (sub == HID_END) begin
               sub <= '0;
               idx <= (idx == HID_LASTJ) ? '0 : idx + 1'b1;
             end else sub <= sub + 1'b1;
        OUT: if (sub == OUT_END) begin
               sub <= '0;
               idx <= (idx == OUT_LASTJ) ? '0 : idx + 1'b1;
             end else sub <= sub + 1'b1;
        default: begin
          idx <= '0;
          sub <= '0;
        end
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    accept    = start && !start_d && (state == IDLE || state == DONE);
    load      = 1'b0;
    hid       = 1'b0;
    out_phase = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: if (accept) nxt = LOAD;
      LOAD: begin
        load = 1'b1;
        nxt  = HID;
      end
      HID: begin
        hid = 1'b1;
        if (sub == HID_END && idx == HID_LASTJ) nxt = OUT;
      end
      OUT: begin
        out_phase = 1'b1;
        if (sub == OUT_END && idx == OUT_LASTJ) nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (accept) nxt = LOAD;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef NN_PERF_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cycle_count <= '0;
    else if (accept)                          cycle_count <= '0;
    else if (state != IDLE && state != DONE)  cycle_count <= cycle_count + 16'd1;
  end
`endif

  neural_network_datapath #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .AW(AW), .JW(JW), .SW(SW)
  ) datapath (
    .clk       (clk),
    .rst       (rst),
    .inputLayer(inputLayer),
    .load      (load),
    .hid       (hid),
    .out_phase (out_phase),
    .idx       (idx),
    .sub       (sub),
    .result    (result)
  );
endmodule

// File: tb/tb_neural_network.sv
// tb/tb_neural_network.sv - directed + model-checked bench for neural_network.
module tb_neural_network;
  localparam int N_IN = 62, N_HID = 30, N_OUT = 10, LAT = 2241;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [8*N_IN-1:0]  inputLayer;
  logic [3:0]         result;
  logic               ready;
`ifdef NN_PERF_COUNTER_EN
  logic [15:0]        cycle_count;
`endif

  always #5 clk = ~clk;

  neural_network dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .inputLayer (inputLayer),
    .result     (result),
`ifdef NN_PERF_COUNTER_EN
    .ready      (ready),
    .cycle_count(cycle_count)
`else
    .ready      (ready)
`endif
  );

  logic [7:0] x [N_IN];
  logic [7:0] wh [N_HID*N_IN];
  logic [7:0] bh [N_HID];
  logic [7:0] wo [N_OUT*N_HID];
  logic [7:0] bo [N_OUT];

  int checks = 0, errors = 0;
  int cyc = 0, t_acc = 0, exp_res = 0, rises = 0;
  bit running = 1'b0;
  logic ready_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sm(input logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  // Reference classifier written straight from the arithmetic definition
  function automatic int model_result();
    int h [N_HID];
    int acc, o, best, bestv;
    for (int j = 0; j < N_HID; j++) begin
      acc = sm(bh[j]) * 128;
      for (int i = 0; i < N_IN; i++) acc += sm(x[i]) * sm(wh[j*N_IN+i]);
      if (acc < 0)             h[j] = 0;
      else if (acc / 128 > 127) h[j] = 127;
      else                      h[j] = acc / 128;
    end
    best = 0; bestv = 0;
    for (int k = 0; k < N_OUT; k++) begin
      o = sm(bo[k]) * 128;
      for (int j = 0; j < N_HID; j++) o += h[j] * sm(wo[k*N_HID+j]);
      if (k == 0 || o > bestv) begin
        bestv = o;
        best  = k;
      end
    end
    return best;
  endfunction

  task automatic clear_params();
    foreach (x[i])  x[i]  = 8'h00;
    foreach (wh[i]) wh[i] = 8'h00;
    foreach (bh[i]) bh[i] = 8'h00;
    foreach (wo[i]) wo[i] = 8'h00;
    foreach (bo[i]) bo[i] = 8'h00;
  endtask

  task automatic sync_params();
    for (int i = 0; i < N_HID*N_IN; i++)  dut.datapath.Wh_Array[i] = wh[i];
    for (int i = 0; i < N_HID; i++)       dut.datapath.Bh_Array[i] = bh[i];
    for (int i = 0; i < N_OUT*N_HID; i++) dut.datapath.Wo_Array[i] = wo[i];
    for (int i = 0; i < N_OUT; i++)       dut.datapath.Bo_Array[i] = bo[i];
    for (int i = 0; i < N_IN; i++)        inputLayer[8*i +: 8] = x[i];
  endtask

  task automatic go(input int hold);
    @(negedge clk);
    sync_params();
    exp_res = model_result();
    start   = 1'b1;
    t_acc   = cyc + 1;
    running = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lit);
    int n = 0;
    while (!ready && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, cyc - t_acc, LAT);
    chk({name, "_result"}, result, lit);
  endtask

  // Every cycle: ready must follow the accepted-start timeline; when ready, outputs must match the model
  always @(posedge clk) begin
    bit exp_r;
    cyc++;
    #2;
    if (!rst) begin
      exp_r = running && (cyc - t_acc >= LAT);
      chk("ready_track", ready, exp_r);
      if (exp_r) begin
        chk("result_model", result, exp_res);
`ifdef NN_PERF_COUNTER_EN
        chk("cycle_count", cycle_count, LAT);
`endif
      end
      if (ready && !ready_q) rises++;
      ready_q = ready;
    end else ready_q = 1'b0;
  end

  initial begin
    int r0;
    rst = 1'b1; start = 1'b0; inputLayer = '0;
    clear_params();
    sync_params();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_result", result, 0);

    // Bias-only argmax
    bo[7] = 8'h05;
    chk("model_bias", model_result(), 7);
    go(1);
    wait_done("bias", 7);

    // Asynchronous reset mid-cycle clears outputs immediately
    @(posedge clk);
    #3 rst = 1'b1;
    running = 1'b0;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_result", result, 0);
    @(negedge clk) rst = 1'b0;

    // Ties resolve to the lowest index; a negative bias loses
    clear_params();
    bo[3] = 8'h10; bo[8] = 8'h10;
    chk("model_tie", model_result(), 3);
    go(1);
    wait_done("tie", 3);
    bo[3] = 8'h90;
    chk("model_neg", model_result(), 8);
    go(1);
    wait_done("neg_bias", 8);

    // Hidden path: h[0]=126 drives class 2; negative weight is clipped by ReLU
    clear_params();
    x[0] = 8'h7F; wh[0] = 8'h7F; wo[2*N_HID] = 8'h01;
    chk("model_hidden", model_result(), 2);
    go(1);
    wait_done("hidden", 2);
    wh[0] = 8'hFF;
    chk("model_relu", model_result(), 0);
    go(1);
    wait_done("relu", 0);

    // Start held two cycles -> exactly one inference
    clear_params();
    bo[5] = 8'h22;
    r0 = rises;
    go(2);
    wait_done("hold", 5);
    repeat (40) @(negedge clk);
    chk("hold_rises", rises, r0 + 1);

    // Start pulse mid-computation is ignored
    bo[5] = 8'h00; bo[9] = 8'h01;
    go(1);
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("midpulse", 9);

    // Reset at cycle 1000 aborts; the restart completes normally
    bo[1] = 8'h7F;
    go(1);
    while (cyc - t_acc < 1000) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    running = 1'b0;
    #1;
    chk("abort_ready", ready, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    go(1);
    wait_done("restart", 1);

    // Random parameter sets checked against the model
    for (int t = 0; t < 4; t++) begin
      foreach (x[i])  x[i]  = 8'($urandom_range(0, 255));
      foreach (wh[i]) wh[i] = 8'($urandom_range(0, 255));
      foreach (bh[i]) bh[i] = 8'($urandom_range(0, 255));
      foreach (wo[i]) wo[i] = 8'($urandom_range(0, 255));
      foreach (bo[i]) bo[i] = 8'($urandom_range(0, 255));
      go(1);
      wait_done("random", model_result());
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
